// File: rtl/gpio_ctrl_seq.sv
// gpio_ctrl_seq: accepts a {sel, enable, drop} target over valid/ready and
// walks the registered GPIO control word {sel, drop, enable} through a
// break-before-make sequence so sel never moves while the mux is enabled.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a command, s_ready high
//   DISABLE | enable forced low, old sel held, SETTLE_CYCLES dwell
//   SWITCH  | new sel applied with enable low, SETTLE_CYCLES dwell
//   DROP    | drop bit high, sel/enable unchanged, DROP_CYCLES dwell
//   APPLY   | requested enable applied, done pulses, one cycle
module gpio_ctrl_seq #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DROP_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] s_sel,
  input  logic       s_enable,
  input  logic       s_drop,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [4:0] gpio,
  output logic       busy,
  output logic       done
);

  localparam int MAXC = (SETTLE_CYCLES > DROP_CYCLES) ? SETTLE_CYCLES : DROP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DROP_LOAD   = CW'(DROP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DISABLE = 3'd1,
    SWITCH  = 3'd2,
    DROP    = 3'd3,
    APPLY   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    cur_sel, cur_sel_n;
  logic          cur_en, cur_en_n;
  logic          cur_drop, cur_drop_n;
  logic [2:0]    cap_sel, cap_sel_n;
  logic          cap_en, cap_en_n;
  logic          cap_drop, cap_drop_n;
  logic          enter;
  logic [2:0]    tgt_sel;
  logic          tgt_en;

  // State, dwell counter, current GPIO fields and captured command
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_sel  <= '0;
      cur_en   <= 1'b0;
      cur_drop <= 1'b0;
      cap_sel  <= '0;
      cap_en   <= 1'b0;
      cap_drop <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_sel  <= cur_sel_n;
      cur_en   <= cur_en_n;
      cur_drop <= cur_drop_n;
      cap_sel  <= cap_sel_n;
      cap_en   <= cap_en_n;
      cap_drop <= cap_drop_n;
    end
  end

  // Next-state selection plus the entry actions of the state being entered
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cur_sel_n  = cur_sel;
    cur_en_n   = cur_en;
    cur_drop_n = cur_drop;
    cap_sel_n  = cap_sel;
    cap_en_n   = cap_en;
    cap_drop_n = cap_drop;
    enter      = 1'b0;
    // At the accept edge the capture registers are not loaded yet, so the
    // entry actions must use the live inputs.
    tgt_sel    = (state == IDLE) ? s_sel : cap_sel;
    tgt_en     = (state == IDLE) ? s_enable : cap_en;

    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          cap_sel_n  = s_sel;
          cap_en_n   = s_enable;
          cap_drop_n = s_drop;
          enter      = 1'b1;
          if ((s_sel != cur_sel) && cur_en) state_n = DISABLE;
          else if (s_sel != cur_sel)        state_n = SWITCH;
          else if (s_drop)                  state_n = DROP;
          else                              state_n = APPLY;
        end
      end
      DISABLE: begin
        // enable is already low here, so the sel change always follows
        if (cnt == '0) begin
          state_n = SWITCH;
          enter   = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SWITCH: begin
        if (cnt == '0) begin
          state_n = cap_drop ? DROP : APPLY;
          enter   = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DROP: begin
        if (cnt == '0) begin
          state_n = APPLY;
          enter   = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      APPLY: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (enter) begin
      case (state_n)
        DISABLE: begin
          cur_en_n   = 1'b0;
          cur_drop_n = 1'b0;
          cnt_n      = SETTLE_LOAD;
        end
        SWITCH: begin
          cur_sel_n  = tgt_sel;
          cur_en_n   = 1'b0;
          cur_drop_n = 1'b0;
          cnt_n      = SETTLE_LOAD;
        end
        DROP: begin
          cur_drop_n = 1'b1;
          cnt_n      = DROP_LOAD;
        end
        APPLY: begin
          cur_en_n   = tgt_en;
          cur_drop_n = 1'b0;
          cnt_n      = '0;
        end
        default: begin
          cnt_n = '0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; ready is also held low during reset
  always_comb begin
    gpio    = {cur_sel, cur_drop, cur_en};
    s_ready = (state == IDLE) && !rst;
    busy    = !s_ready;
    done    = (state == APPLY);
  end

endmodule

// File: tb/tb_gpio_ctrl_seq.sv
// Directed testbench for gpio_ctrl_seq (SETTLE_CYCLES = 4, DROP_CYCLES = 8).
module tb_gpio_ctrl_seq;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] s_sel;
  logic       s_enable;
  logic       s_drop;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] gpio;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Model of the last applied GPIO state
  logic [2:0] ms = 3'd0;
  logic       me = 1'b0;

  typedef struct {
    logic [2:0] sel;
    logic       en;
    logic       drop;
    int         nbusy;
    logic [4:0] fin;
  } vec_t;

  vec_t tbl [8];

  gpio_ctrl_seq #(.SETTLE_CYCLES(S), .DROP_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_sel    (s_sel),
    .s_enable (s_enable),
    .s_drop   (s_drop),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .gpio     (gpio),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Present a command at the next negedge; it is accepted at the following posedge
  task automatic do_accept(input logic [2:0] sel, input logic en, input logic drop, input bit hold);
    @(negedge clk);
    chk("ready_before_accept", s_ready, 1'b1);
    s_sel    = sel;
    s_enable = en;
    s_drop   = drop;
    s_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) s_valid = 1'b0;
  endtask

  // Follow the busy period of an accepted command against a cycle-by-cycle model
  task automatic watch(input string nm, input logic [2:0] sel, input logic en, input logic drop,
                       input int exp_busy, input logic [4:0] exp_fin,
                       input bit junk, input logic [2:0] nsel, input logic nen, input logic ndrop);
    logic [4:0] q[$];
    logic [4:0] prev;
    int n;
    bit fin;
    logic en_now;
    q = {};
    if (sel != ms && me) for (int k = 0; k < S; k++) q.push_back({ms, 1'b0, 1'b0});
    if (sel != ms)       for (int k = 0; k < S; k++) q.push_back({sel, 1'b0, 1'b0});
    en_now = (sel != ms) ? 1'b0 : me;
    if (drop)            for (int k = 0; k < D; k++) q.push_back({sel, 1'b1, en_now});
    q.push_back({sel, 1'b0, en});

    prev = {ms, 1'b0, me};
    n = 0;
    fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (!busy) begin
        fin = 1;
      end else begin
        if (n < q.size()) chk({nm, "_gpio"}, gpio, q[n]);
        else              chk({nm, "_overrun"}, 1, 0);
        chk({nm, "_busy_vs_ready"}, busy, !s_ready);
        chk({nm, "_done"}, done, (n == q.size() - 1));
        chk({nm, "_sel_while_en"}, (gpio[4:2] != prev[4:2]) && (prev[0] || gpio[0]), 0);
        chk({nm, "_drop_with_sel"}, (gpio[4:2] != prev[4:2]) && gpio[1], 0);
        prev = gpio;
        n++;
        if (junk) begin
          if (n == q.size()) begin
            s_sel = nsel; s_enable = nen; s_drop = ndrop;
          end else begin
            s_sel    = 3'($urandom_range(0, 7));
            s_enable = 1'($urandom_range(0, 1));
            s_drop   = 1'($urandom_range(0, 1));
          end
        end
      end
    end
    if (!fin) chk({nm, "_timeout"}, 1, 0);
    chk({nm, "_busy_cycles"}, n, exp_busy);
    chk({nm, "_final_gpio"}, gpio, exp_fin);
    chk({nm, "_ready_after"}, s_ready, 1'b1);
    chk({nm, "_done_idle"}, done, 1'b0);
    ms = sel;
    me = en;
  endtask

  initial begin
    tbl[0] = '{3'd5, 1'b1, 1'b0,  5, 5'b10101};
    tbl[1] = '{3'd2, 1'b1, 1'b1, 17, 5'b01001};
    tbl[2] = '{3'd2, 1'b0, 1'b0,  1, 5'b01000};
    tbl[3] = '{3'd2, 1'b0, 1'b1,  9, 5'b01000};
    tbl[4] = '{3'd7, 1'b0, 1'b0,  5, 5'b11100};
    tbl[5] = '{3'd7, 1'b1, 1'b0,  1, 5'b11101};
    tbl[6] = '{3'd0, 1'b1, 1'b0,  9, 5'b00001};
    tbl[7] = '{3'd0, 1'b1, 1'b1,  9, 5'b00011 & 5'b11101};

    // Reset held with a valid command pending: nothing accepted
    rst = 1'b1; s_valid = 1'b1; s_sel = 3'd3; s_enable = 1'b1; s_drop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gpio", gpio, 5'b00000);
      chk("rst_ready", s_ready, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_done", done, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1'b1);
    chk("post_rst_gpio", gpio, 5'b00000);

    // Table of commands run back from reset state
    for (int v = 0; v < 8; v++) begin
      do_accept(tbl[v].sel, tbl[v].en, tbl[v].drop, 0);
      watch($sformatf("vec%0d", v), tbl[v].sel, tbl[v].en, tbl[v].drop,
            tbl[v].nbusy, tbl[v].fin, 0, 3'd0, 1'b0, 1'b0);
    end

    // Reset in the third DROP cycle: outputs clear, no done pulse
    do_accept(3'd0, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_drop_gpio", gpio, 5'b00011);
      chk("mid_drop_done", done, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gpio", gpio, 5'b00000);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", s_ready, 1'b1);
    chk("mid_rel_gpio", gpio, 5'b00000);
    chk("mid_rel_done", done, 1'b0);
    ms = 3'd0; me = 1'b0;
    do_accept(3'd3, 1'b1, 1'b0, 0);
    watch("after_rst", 3'd3, 1'b1, 1'b0, 5, 5'b01101, 0, 3'd0, 1'b0, 1'b0);

    // s_valid held high with payload churning; B must follow one idle cycle after APPLY
    do_accept(3'd4, 1'b1, 1'b0, 1);
    watch("b2b_a", 3'd4, 1'b1, 1'b0, 9, 5'b10001, 1, 3'd1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    watch("b2b_b", 3'd1, 1'b0, 1'b0, 9, 5'b00100, 0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
